pipe_cla_adder: RTL and testbench
=================================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/sum width in bits (>=1).
REQ-002 SHALL provide parameter GROUP, default 4, bits per lookahead group (1..WIDTH).
REQ-003 SHALL provide port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port io_in_valid  input  1  operand beat present.
REQ-006 SHALL provide port io_in_ready  output  1  block accepts operand beat this cycle.
REQ-007 SHALL provide ports io_a, io_b  input  WIDTH  operands, unsigned two's-complement bit vectors.
REQ-008 SHALL provide port io_c_in  input  1  carry-in.
REQ-009 SHALL provide port io_out_valid  output  1  result beat present.
REQ-010 SHALL provide port io_out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port io_s  output  WIDTH  sum, io_a+io_b+io_c_in mod 2^WIDTH.
REQ-012 SHALL provide port io_c_out  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL provide ports io_cpg_p, io_cpg_g  output  1  word propagate (AND over bits of a|b) and word generate.

Function
REQ-014 SHALL split operands into N=ceil(WIDTH/GROUP) groups from LSB; group N-1 holds the WIDTH mod GROUP leftover bits when nonzero.
REQ-015 SHALL use bit p=a|b, g=a&b; group P/G and carries per lookahead recurrence c[i+1]=g[i] | p[i]&c[i].
REQ-016 Stage 1 SHALL register per-group P, G, sum-with-carry-0, sum-with-carry-1, plus io_c_in.
REQ-017 Stage 2 SHALL compute group carries from registered P/G and io_c_in, select group sums, and register io_s, io_c_out, io_cpg_p, io_cpg_g.
REQ-018 Latency SHALL be exactly 2 cycles from accepted beat (io_in_valid & io_in_ready) to io_out_valid when unstalled.
REQ-019 Each stage SHALL hold a valid bit; a stage advances when its successor is empty or advancing; stage 2 advances when io_out_ready=1.
REQ-020 io_in_ready SHALL be !stage1_valid | stage1_advance (combinational through io_out_ready); no bubbles at full throughput.
REQ-021 With io_out_valid=1 and io_out_ready=0, io_s/io_c_out/io_cpg_* SHALL hold stable until the handshake completes.
REQ-022 Results SHALL emerge in acceptance order; no beat dropped or duplicated under any valid/ready pattern.
REQ-023 Simultaneous stage-2 drain and new accept SHALL both occur in the same cycle.
REQ-024 io_in_valid with io_in_ready=0 SHALL be ignored; operands need not be held by the block.

Reset
REQ-025 Reset SHALL asynchronously clear both stage valid bits and all data registers to 0.
REQ-026 During and after reset: io_out_valid=0, io_s=0, io_c_out=0, io_cpg_p=0, io_cpg_g=0, io_in_ready=1 from first clock after deassertion.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; no result from pre-reset beats appears.

Configuration
REQ-028 Macro PIPE_CLA_ADDER_OVF_EN defined SHALL add output io_ovf (1 bit), signed overflow = carry into MSB XOR io_c_out, registered in stage 2, reset 0.
REQ-029 Macro undefined SHALL omit io_ovf port and its logic; all other behaviour identical.

Verification
REQ-030 WIDTH=32: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> 2 cycles later s=0x00000000, c_out=1, cpg_p=1, cpg_g=1.
REQ-031 WIDTH=5, GROUP=4 (leftover group): a=0x1F, b=0x00, c_in=1 -> s=0x00, c_out=1, cpg_p=1, cpg_g=0.
REQ-032 Back-to-back 8 random beats, out_ready=1 -> 8 results on consecutive cycles, in order, matching reference sum.
REQ-033 out_ready=0 for 5 cycles with 3 beats offered -> in_ready falls after 2 accepted, outputs stable; release -> 3 correct results in order.
REQ-034 Assert reset with 2 beats in flight -> out_valid=0 immediately; no stale result after reset release.
REQ-035 With PIPE_CLA_ADDER_OVF_EN, WIDTH=32: a=0x7FFFFFFF, b=0x00000001 -> ovf=1; a=0x80000000, b=0xFFFFFFFF -> ovf=1, c_out=1.

Source files
------------

// File: rtl/pipe_cla_adder_if.sv
// Operand/result handshake bundle for pipe_cla_adder.
// PIPE_CLA_ADDER_OVF_EN adds the signed-overflow result signal io_ovf.
interface pipe_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_c_in;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_s;
  logic             io_c_out;
  logic             io_cpg_p;
  logic             io_cpg_g;

`ifdef PIPE_CLA_ADDER_OVF_EN
  logic             io_ovf;

  modport master (
    output io_in_valid, io_a, io_b, io_c_in, io_out_ready,
    input  io_in_ready, io_out_valid, io_s, io_c_out, io_cpg_p, io_cpg_g, io_ovf
  );
  modport slave (
    input  io_in_valid, io_a, io_b, io_c_in, io_out_ready,
    output io_in_ready, io_out_valid, io_s, io_c_out, io_cpg_p, io_cpg_g, io_ovf
  );
`else
  modport master (
    output io_in_valid, io_a, io_b, io_c_in, io_out_ready,
    input  io_in_ready, io_out_valid, io_s, io_c_out, io_cpg_p, io_cpg_g
  );
  modport slave (
    input  io_in_valid, io_a, io_b, io_c_in, io_out_ready,
    output io_in_ready, io_out_valid, io_s, io_c_out, io_cpg_p, io_cpg_g
  );
`endif
endinterface

// File: rtl/pipe_cla_adder.sv
// Two-stage carry-lookahead adder with valid/ready flow control.
// Optional macro PIPE_CLA_ADDER_OVF_EN adds the registered signed-overflow output io_ovf.
module pipe_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input logic             clock,
  input logic             reset,
  pipe_cla_adder_if.slave bus
);
  localparam int N = (WIDTH + GROUP - 1) / GROUP;

  function automatic logic carry_next(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

  logic             vld_p1;
  logic [N-1:0]     grp_p_p1;
  logic [N-1:0]     grp_g_p1;
  logic [WIDTH-1:0] s0_p1;
  logic [WIDTH-1:0] s1_p1;
  logic             cin_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] s_p2;
  logic             c_out_p2;
  logic             cpg_p_p2;
  logic             cpg_g_p2;

  logic             take_p2;
  logic             adv_p1;
  logic             ready;
  logic             accept;

  // Stage 2 can take a beat when it is empty or its result is leaving.
  assign take_p2 = !vld_p2 | bus.io_out_ready;
  assign adv_p1  = vld_p1 & take_p2;
  assign ready   = !vld_p1 | take_p2;
  assign accept  = bus.io_in_valid & ready;

  // ---- stage 0 -> 1: per-group propagate/generate and conditional sums ----
  logic [N-1:0]     grp_p_n;
  logic [N-1:0]     grp_g_n;
  logic [WIDTH-1:0] s0_n;
  logic [WIDTH-1:0] s1_n;

  always_comb begin
    logic pb, gb, c0, c1;
    grp_p_n = '0;
    grp_g_n = '0;
    s0_n    = '0;
    s1_n    = '0;
    pb      = 1'b0;
    gb      = 1'b0;
    c0      = 1'b0;
    c1      = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      // The last group simply ends at WIDTH-1 when WIDTH is not a multiple of GROUP.
      if (j % GROUP == 0) begin
        c0 = 1'b0;
        c1 = 1'b1;
        grp_p_n[j/GROUP] = 1'b1;
      end
      pb = bus.io_a[j] | bus.io_b[j];
      gb = bus.io_a[j] & bus.io_b[j];
      s0_n[j] = bus.io_a[j] ^ bus.io_b[j] ^ c0;
      s1_n[j] = bus.io_a[j] ^ bus.io_b[j] ^ c1;
      c0 = carry_next(gb, pb, c0);
      c1 = carry_next(gb, pb, c1);
      grp_g_n[j/GROUP] = carry_next(gb, pb, grp_g_n[j/GROUP]);
      grp_p_n[j/GROUP] = grp_p_n[j/GROUP] & pb;
    end
  end

`ifdef PIPE_CLA_ADDER_OVF_EN
  logic abx_msb_p1;
  logic abx_msb_p2;
  logic ovf_p2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (ready) begin
      vld_p1 <= bus.io_in_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grp_p_p1 <= '0;
      grp_g_p1 <= '0;
      s0_p1    <= '0;
      s1_p1    <= '0;
      cin_p1   <= 1'b0;
`ifdef PIPE_CLA_ADDER_OVF_EN
      abx_msb_p1 <= 1'b0;
`endif
    end else if (accept) begin
      grp_p_p1 <= grp_p_n;
      grp_g_p1 <= grp_g_n;
      s0_p1    <= s0_n;
      s1_p1    <= s1_n;
      cin_p1   <= bus.io_c_in;
`ifdef PIPE_CLA_ADDER_OVF_EN
      abx_msb_p1 <= bus.io_a[WIDTH-1] ^ bus.io_b[WIDTH-1];
`endif
    end
  end

  // ---- stage 1 -> 2: group carries, sum select, word P/G ----
  logic [N:0]       c_n;
  logic [WIDTH-1:0] s_n;
  logic             word_g_n;

  always_comb begin
    c_n      = '0;
    c_n[0]   = cin_p1;
    word_g_n = 1'b0;
    s_n      = '0;
    for (int i = 0; i < N; i++) begin
      c_n[i+1] = carry_next(grp_g_p1[i], grp_p_p1[i], c_n[i]);
      word_g_n = carry_next(grp_g_p1[i], grp_p_p1[i], word_g_n);
    end
    for (int j = 0; j < WIDTH; j++) begin
      s_n[j] = c_n[j/GROUP] ? s1_p1[j] : s0_p1[j];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
    end else if (take_p2) begin
      vld_p2 <= vld_p1;
    end
  end

  // Result registers load only with a real beat so a stalled output stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_p2     <= '0;
      c_out_p2 <= 1'b0;
      cpg_p_p2 <= 1'b0;
      cpg_g_p2 <= 1'b0;
`ifdef PIPE_CLA_ADDER_OVF_EN
      ovf_p2   <= 1'b0;
`endif
    end else if (adv_p1) begin
      s_p2     <= s_n;
      c_out_p2 <= c_n[N];
      cpg_p_p2 <= &grp_p_p1;
      cpg_g_p2 <= word_g_n;
`ifdef PIPE_CLA_ADDER_OVF_EN
      // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
      ovf_p2   <= (s_n[WIDTH-1] ^ abx_msb_p1) ^ c_n[N];
`endif
    end
  end

`ifdef PIPE_CLA_ADDER_OVF_EN
  assign abx_msb_p2 = ovf_p2;
  assign bus.io_ovf = abx_msb_p2;
`endif

  assign bus.io_in_ready  = ready;
  assign bus.io_out_valid = vld_p2;
  assign bus.io_s         = s_p2;
  assign bus.io_c_out     = c_out_p2;
  assign bus.io_cpg_p     = cpg_p_p2;
  assign bus.io_cpg_g     = cpg_g_p2;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed self-checking bench for pipe_cla_adder (32-bit and 5-bit leftover-group instances).
module tb_pipe_cla_adder;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  pipe_cla_adder_if #(.WIDTH(32)) bus ();
  pipe_cla_adder_if #(.WIDTH(5))  bus5 ();

  pipe_cla_adder #(.WIDTH(32), .GROUP(4)) dut  (.clock(clock), .reset(reset), .bus(bus.slave));
  pipe_cla_adder #(.WIDTH(5),  .GROUP(4)) dut5 (.clock(clock), .reset(reset), .bus(bus5.slave));

  task automatic idle_inputs();
    bus.io_in_valid   = 1'b0;
    bus.io_a          = '0;
    bus.io_b          = '0;
    bus.io_c_in       = 1'b0;
    bus.io_out_ready  = 1'b1;
    bus5.io_in_valid  = 1'b0;
    bus5.io_a         = '0;
    bus5.io_b         = '0;
    bus5.io_c_in      = 1'b0;
    bus5.io_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.io_out_valid); end
    checks++;
    if (bus.io_s !== 32'h0) begin errors++; $display("FAIL reset_s: got %h expected 00000000", bus.io_s); end
    checks++;
    if ({bus.io_c_out, bus.io_cpg_p, bus.io_cpg_g} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {bus.io_c_out, bus.io_cpg_p, bus.io_cpg_g});
    end
`ifdef PIPE_CLA_ADDER_OVF_EN
    checks++;
    if (bus.io_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.io_ovf); end
`endif
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.io_in_ready); end
    checks++;
    if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", bus.io_out_valid); end
  endtask

  task automatic test_single_beats();
    logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'hAAAAAAAA, 32'h00000000};
    logic [31:0] tb [5] = '{32'h00000001, 32'h11111111, 32'h80000000, 32'h55555555, 32'h00000000};
    logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [5] = '{32'h00000000, 32'h2345678A, 32'h00000000, 32'h00000000, 32'h00000001};
    logic [2:0]  ef [5] = '{3'b111, 3'b000, 3'b101, 3'b110, 3'b000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.io_in_valid = 1'b1;
      bus.io_a = ta[i];
      bus.io_b = tb[i];
      bus.io_c_in = tc[i];
      @(negedge clock);
      bus.io_in_valid = 1'b0;
      checks++;
      if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %b expected 0", i, bus.io_out_valid); end
      @(negedge clock);
      checks++;
      if (bus.io_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, bus.io_out_valid); end
      checks++;
      if (bus.io_s !== es[i]) begin errors++; $display("FAIL single_s[%0d]: got %h expected %h", i, bus.io_s, es[i]); end
      checks++;
      if ({bus.io_c_out, bus.io_cpg_p, bus.io_cpg_g} !== ef[i]) begin
        errors++; $display("FAIL single_cout_p_g[%0d]: got %b expected %b", i, {bus.io_c_out, bus.io_cpg_p, bus.io_cpg_g}, ef[i]);
      end
    end
  endtask

  task automatic test_leftover_group();
    logic [4:0] ta [3] = '{5'h1F, 5'h0F, 5'h10};
    logic [4:0] tb [3] = '{5'h00, 5'h01, 5'h10};
    logic       tc [3] = '{1'b1, 1'b0, 1'b0};
    logic [4:0] es [3] = '{5'h00, 5'h10, 5'h00};
    logic [2:0] ef [3] = '{3'b110, 3'b000, 3'b101};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus5.io_in_valid = 1'b1;
      bus5.io_a = ta[i];
      bus5.io_b = tb[i];
      bus5.io_c_in = tc[i];
      @(negedge clock);
      bus5.io_in_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (bus5.io_out_valid !== 1'b1) begin errors++; $display("FAIL left_valid[%0d]: got %b expected 1", i, bus5.io_out_valid); end
      checks++;
      if (bus5.io_s !== es[i]) begin errors++; $display("FAIL left_s[%0d]: got %h expected %h", i, bus5.io_s, es[i]); end
      checks++;
      if ({bus5.io_c_out, bus5.io_cpg_p, bus5.io_cpg_g} !== ef[i]) begin
        errors++; $display("FAIL left_cout_p_g[%0d]: got %b expected %b", i, {bus5.io_c_out, bus5.io_cpg_p, bus5.io_cpg_g}, ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra [8];
    logic [31:0] rb [8];
    logic        rc [8];
    logic [31:0] es [8];
    logic        ec [8];
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rc[i] = 1'($urandom_range(1));
      {ec[i], es[i]} = {1'b0, ra[i]} + {1'b0, rb[i]} + {32'h0, rc[i]};
    end
    bus.io_out_ready = 1'b1;
    for (int n = 0; n < 11; n++) begin
      @(negedge clock);
      checks++;
      if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", n, bus.io_in_ready); end
      if (n >= 2 && n < 10) begin
        checks++;
        if (bus.io_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", n, bus.io_out_valid); end
        checks++;
        if ({bus.io_c_out, bus.io_s} !== {ec[n-2], es[n-2]}) begin
          errors++; $display("FAIL b2b_sum[%0d]: got %b_%h expected %b_%h", n-2, bus.io_c_out, bus.io_s, ec[n-2], es[n-2]);
        end
      end else begin
        checks++;
        if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got %b expected 0", n, bus.io_out_valid); end
      end
      if (n < 8) begin
        bus.io_in_valid = 1'b1;
        bus.io_a = ra[n];
        bus.io_b = rb[n];
        bus.io_c_in = rc[n];
      end else begin
        bus.io_in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ba [3] = '{32'h00000001, 32'h00000010, 32'hFFFFFFFF};
    logic [31:0] bb [3] = '{32'h00000002, 32'h00000020, 32'hFFFFFFFF};
    logic        bc [3] = '{1'b0, 1'b1, 1'b1};
    logic [32:0] eo [3] = '{33'h0_00000003, 33'h0_00000031, 33'h1_FFFFFFFF};
    logic        er [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int          ei [9] = '{-1, -1, 0, 0, 0, 0, 1, 2, -1};
    int          sent = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clock);
      bus.io_out_ready = (cyc >= 5);
      bus.io_in_valid  = (sent < 3);
      if (sent < 3) begin
        bus.io_a = ba[sent];
        bus.io_b = bb[sent];
        bus.io_c_in = bc[sent];
      end
      #1;
      checks++;
      if (bus.io_in_ready !== er[cyc]) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected %b", cyc, bus.io_in_ready, er[cyc]); end
      if (ei[cyc] < 0) begin
        checks++;
        if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle[%0d]: got %b expected 0", cyc, bus.io_out_valid); end
      end else begin
        checks++;
        if ({bus.io_out_valid, bus.io_c_out, bus.io_s} !== {1'b1, eo[ei[cyc]]}) begin
          errors++; $display("FAIL stall_out[%0d]: got %b_%b_%h expected 1_%h", cyc, bus.io_out_valid, bus.io_c_out, bus.io_s, eo[ei[cyc]]);
        end
      end
      if (bus.io_in_valid && bus.io_in_ready) sent++;
    end
    bus.io_in_valid = 1'b0;
    checks++;
    if (sent !== 3) begin errors++; $display("FAIL stall_accepted: got %0d expected 3", sent); end
  endtask

  task automatic test_reset_midflight();
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      bus.io_in_valid = 1'b1;
      bus.io_a = 32'h0000_1000 + i;
      bus.io_b = 32'h0000_0100;
      bus.io_c_in = 1'b0;
    end
    @(negedge clock);
    bus.io_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.io_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.io_out_valid); end
    checks++;
    if (bus.io_s !== 32'h0) begin errors++; $display("FAIL midreset_s: got %h expected 00000000", bus.io_s); end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      checks++;
      if ({bus.io_out_valid, bus.io_in_ready} !== 2'b01) begin
        errors++; $display("FAIL midreset_stale[%0d]: got valid=%b ready=%b expected valid=0 ready=1", n, bus.io_out_valid, bus.io_in_ready);
      end
    end
  endtask

`ifdef PIPE_CLA_ADDER_OVF_EN
  task automatic test_ovf();
    logic [31:0] ta [2] = '{32'h7FFFFFFF, 32'h80000000};
    logic [31:0] tb [2] = '{32'h00000001, 32'hFFFFFFFF};
    logic [31:0] es [2] = '{32'h80000000, 32'h7FFFFFFF};
    logic [1:0]  ef [2] = '{2'b10, 2'b11};
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      bus.io_in_valid = 1'b1;
      bus.io_a = ta[i];
      bus.io_b = tb[i];
      bus.io_c_in = 1'b0;
      @(negedge clock);
      bus.io_in_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.io_s !== es[i]) begin errors++; $display("FAIL ovf_s[%0d]: got %h expected %h", i, bus.io_s, es[i]); end
      checks++;
      if ({bus.io_ovf, bus.io_c_out} !== ef[i]) begin
        errors++; $display("FAIL ovf_flags[%0d]: got %b expected %b", i, {bus.io_ovf, bus.io_c_out}, ef[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beats();
    test_leftover_group();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef PIPE_CLA_ADDER_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
